parking_gate_arbiter: RTL
=========================

# parking_gate_arbiter

Shares one 8-slot parking occupancy store between several entry and exit gates. Gates raise level requests. A two-class round-robin arbiter serves one request at a time: arrivals get the lowest free slot and a ticket code; exits are validated against the stored code before the slot is released. It sits between the gate front-ends and the lot status display.

## Interface
- NUM_GATES, 2, number of entry gates and number of exit gates (each class has NUM_GATES requesters)
- NUM_SLOTS, 8, parking slots; SLOT_W = 3 is fixed for 8 slots
- CODE_W, 8, ticket code width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- arr_req  in  NUM_GATES  entry request per gate; level, held until ack
- ext_req  in  NUM_GATES  exit request per gate; level, held until ack
- ext_slot  in  NUM_GATES*3  packed slot claimed by each exit gate; gate g occupies bits [3g+2:3g]
- ext_code  in  NUM_GATES*CODE_W  packed ticket code per exit gate
- arr_ack  out  NUM_GATES  one-cycle ack pulse to the served entry gate
- ext_ack  out  NUM_GATES  one-cycle ack pulse to the served exit gate
- res_ok  out  1  result of the acked transaction; valid only during an ack cycle
- res_slot  out  3  slot allocated (arrival) or released (exit)
- res_code  out  CODE_W  ticket issued (arrival); 0 for exits
- occupancy  out  NUM_SLOTS  bit i = slot i taken
- free_count  out  4  number of free slots, 0..8
- full, empty  out  1  free_count==0 / free_count==8

## Operation
- FSM has four states: IDLE, SERVE, ACK, HOLD.
- **IDLE**
  - If any request is present, latch the grant and go to SERVE.
  - Exit requests have strict priority over arrivals, so space is freed first.
  - Within a class, a round-robin pointer is used. It starts at gate 0 and advances to one past the granted gate.
- **SERVE**, arrival
  - If not full: take the lowest-index free slot. Set its occupancy bit. Store the current LFSR value as its code. res_ok=1.
  - If full: res_ok=0, res_slot=0, res_code=0, no state change.
- **SERVE**, exit
  - res_ok=1 only if occupancy[slot]=1 and ext_code equals the stored code.
  - On res_ok=1: clear the occupancy bit and clear the stored code to 0. res_slot = claimed slot.
  - On res_ok=0: nothing changes.
- **ACK**: pulse the granted ack bit for exactly one cycle. res_* are held from SERVE. Go to HOLD.
- **HOLD**: wait until the granted request is deasserted (4-phase handshake), then go to IDLE. Other requests stay pending.
- **LFSR**
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5. Advances every cycle.
  - Never 0, so a stored code of 0 always means a free slot.
- free_count, full and empty are registered and updated in the same edge as occupancy.

## Timing
- Reset (rst_n low, async) sets:
  - state=IDLE, occupancy=0, all stored codes=0, free_count=8, empty=1, full=0.
  - All acks=0, res_*=0, RR pointers=0, LFSR=8'hA5.
- Latency: request sampled high at edge k gives the occupancy update at edge k+1 and the ack high during cycle k+1..k+2. Minimum turnaround is 4 cycles per transaction.
- Only one transaction is in flight, so arrival and exit never modify the store in the same cycle.
- If a request drops before it is granted, it is ignored. If the granted request drops during SERVE or ACK, the transaction still completes.
- Reset asserted mid-transaction aborts it. No ack is emitted, and the store is cleared.

## Structure
- Shared package parking_pkg holds:
  - the state enum (IDLE, SERVE, ACK, HOLD)
  - SLOT_W=3, LFSR_SEED=8'hA5, LFSR_TAPS
  - the result struct {ok, slot, code}
- Sub-module rr_arbiter (N-bit request in, one-hot grant out, pointer update on an accept strobe). It is instantiated twice, once per class.
- Code storage is an 8×CODE_W register array. No RAM.

## Test plan
- Reset, then arr_req[0] held → ack after 2 cycles, res_ok=1, res_slot=0, res_code=LFSR value sampled; occupancy=8'h01, free_count=7.
- arr_req[0] and arr_req[1] high together (pointer 0), each dropped on its ack → gate 0 gets slot 0 first, then gate 1 gets slot 1; the second grant goes to gate 1 by round-robin.
- Fill all 8 slots, then another arrival → res_ok=0, occupancy=8'hFF, full=1.
- Exit slot 2 with the correct code → res_ok=1, occupancy bit 2 cleared, free_count+1. Exit slot 2 again with the same code → res_ok=0.
- Exit with a wrong code (stored ^ 8'h01), and exit claiming an empty slot → res_ok=0, occupancy unchanged.
- ext_req[1] and arr_req[0] simultaneous while full → exit served first, then the arrival gets the freed slot. Drive rst_n low during SERVE → no ack, occupancy=0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter: FSM states,
// slot/LFSR constants, the transaction result record and the LFSR step.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        ACK,
        HOLD
    } state_t;

    localparam int SLOT_W = 3;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic              ok;
        logic [SLOT_W-1:0] slot;
        logic [LFSR_W-1:0] code;
    } result_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the pointer; the pointer
// moves to one past the granted requester when the grant is accepted.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                grant[(int'(ptr_q) + i) % N] = 1'b1;
                grant_idx = IDX_W'((int'(ptr_q) + i) % N);
                found     = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept && found) begin
            ptr_q <= IDX_W'((int'(grant_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared 8-slot occupancy store serving entry and exit gates one request at
// a time; exits have priority, arrivals get the lowest free slot and a ticket.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_GATES = 2,
    parameter int NUM_SLOTS = 8,
    parameter int CODE_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_GATES-1:0]        arr_req,
    input  logic [NUM_GATES-1:0]        ext_req,
    input  logic [NUM_GATES*SLOT_W-1:0] ext_slot,
    input  logic [NUM_GATES*CODE_W-1:0] ext_code,
    output logic [NUM_GATES-1:0]        arr_ack,
    output logic [NUM_GATES-1:0]        ext_ack,
    output logic                        res_ok,
    output logic [SLOT_W-1:0]           res_slot,
    output logic [CODE_W-1:0]           res_code,
    output logic [NUM_SLOTS-1:0]        occupancy,
    output logic [3:0]                  free_count,
    output logic                        full,
    output logic                        empty
);

    localparam int GIDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

    state_t              state_q, state_d;
    logic [NUM_GATES-1:0] arr_gnt, ext_gnt, gnt_oh_q;
    logic [GIDX_W-1:0]   arr_gidx, ext_gidx, gnt_idx_q;
    logic                arr_any, ext_any, gnt_ext_q, held_req;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [NUM_SLOTS-1:0] occ_q;
    logic [CODE_W-1:0]   codes_q [NUM_SLOTS];
    logic [3:0]          free_q, free_d;
    logic                full_q, empty_q;
    result_t             res_q, serve_res;
    logic [SLOT_W-1:0]   claim_slot, free_idx;
    logic [CODE_W-1:0]   claim_code;
    logic                free_hit;

    assign arr_any = |arr_req;
    assign ext_any = |ext_req;

    rr_arbiter #(.N(NUM_GATES)) u_ext_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (ext_req),
        .accept    (state_q == IDLE),
        .grant     (ext_gnt),
        .grant_idx (ext_gidx)
    );

    // Arrivals only advance their pointer when no exit outranks them.
    rr_arbiter #(.N(NUM_GATES)) u_arr_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arr_req),
        .accept    ((state_q == IDLE) && !ext_any),
        .grant     (arr_gnt),
        .grant_idx (arr_gidx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        held_req = gnt_ext_q ? ext_req[gnt_idx_q] : arr_req[gnt_idx_q];
        state_d  = state_q;
        case (state_q)
            IDLE:    if (ext_any || arr_any) state_d = SERVE;
            SERVE:   state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    if (!held_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        claim_slot = ext_slot[int'(gnt_idx_q)*SLOT_W +: SLOT_W];
        claim_code = ext_code[int'(gnt_idx_q)*CODE_W +: CODE_W];
        free_hit   = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_hit = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
        serve_res = '0;
        if (gnt_ext_q) begin
            serve_res.ok   = occ_q[claim_slot] && (codes_q[claim_slot] == claim_code);
            serve_res.slot = claim_slot;
        end else if (free_hit) begin
            serve_res.ok   = 1'b1;
            serve_res.slot = free_idx;
            serve_res.code = lfsr_q;
        end
        free_d = free_q;
        if (state_q == SERVE && serve_res.ok)
            free_d = gnt_ext_q ? free_q + 4'd1 : free_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= LFSR_SEED;
            gnt_ext_q <= 1'b0;
            gnt_oh_q  <= '0;
            gnt_idx_q <= '0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (state_q == IDLE) begin
                if (ext_any) begin
                    gnt_ext_q <= 1'b1;
                    gnt_oh_q  <= ext_gnt;
                    gnt_idx_q <= ext_gidx;
                end else if (arr_any) begin
                    gnt_ext_q <= 1'b0;
                    gnt_oh_q  <= arr_gnt;
                    gnt_idx_q <= arr_gidx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= '0;
            free_q  <= 4'(NUM_SLOTS);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            res_q   <= '0;
            // NOTE: the code store is plain flops and must be reset, since a zero code marks a free slot.
            for (int i = 0; i < NUM_SLOTS; i++) codes_q[i] <= '0;
        end else begin
            if (state_q == SERVE) begin
                res_q <= serve_res;
                if (serve_res.ok) begin
                    if (gnt_ext_q) begin
                        occ_q[claim_slot]   <= 1'b0;
                        codes_q[claim_slot] <= '0;
                    end else begin
                        occ_q[free_idx]   <= 1'b1;
                        codes_q[free_idx] <= CODE_W'(lfsr_q);
                    end
                end
            end
            free_q  <= free_d;
            full_q  <= (free_d == 4'd0);
            empty_q <= (free_d == 4'(NUM_SLOTS));
        end
    end

    assign arr_ack    = (state_q == ACK && !gnt_ext_q) ? gnt_oh_q : '0;
    assign ext_ack    = (state_q == ACK &&  gnt_ext_q) ? gnt_oh_q : '0;
    assign res_ok     = res_q.ok;
    assign res_slot   = res_q.slot;
    assign res_code   = CODE_W'(res_q.code);
    assign occupancy  = occ_q;
    assign free_count = free_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule
